// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Write-back request bundle between the two write-back requesters (ALU = a,
// memory/load = m) and the register-file write-port arbiter.
//
// Signals (names seen from the arbiter side):
//   a_valid_i / m_valid_i : request valid
//   a_ready_o / m_ready_o : request accepted this cycle (combinational)
//   a_addr_i  / m_addr_i  : destination register  [ADDR_W-1:0]
//   a_data_i  / m_data_i  : write data            [DATA_W-1:0]
//
// Modports:
//   master : requester side (drives valid/addr/data, observes ready)
//   slave  : arbiter side   (observes valid/addr/data, drives ready)
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              a_valid_i;
    logic              a_ready_o;
    logic [ADDR_W-1:0] a_addr_i;
    logic [DATA_W-1:0] a_data_i;

    logic              m_valid_i;
    logic              m_ready_o;
    logic [ADDR_W-1:0] m_addr_i;
    logic [DATA_W-1:0] m_data_i;

    modport master (
        output a_valid_i, a_addr_i, a_data_i,
        output m_valid_i, m_addr_i, m_data_i,
        input  a_ready_o, m_ready_o
    );

    modport slave (
        input  a_valid_i, a_addr_i, a_data_i,
        input  m_valid_i, m_addr_i, m_data_i,
        output a_ready_o, m_ready_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-port controller for the 32 x 64 register file. Shares the single write
// port between the ALU (a) and memory (m) write-back requesters with
// round-robin arbitration, and contains a clear sequencer that zeroes every
// writable register, one per cycle.
//
// Ports:
//   clk_i         : clock, all state on rising edge
//   reset_i       : asynchronous active-low reset
//   wb            : request bundle (regfile_wb_arbiter_if.slave)
//   clear_i       : pulse, starts the clear sequence (ignored while clearing)
//   busy_o        : clear sequence in progress (registered)
//   WR_o          : register file write select   (registered)
//   WD_o          : register file write data     (registered)
//   RegWrite_o    : register file write enable   (registered)
//   last_grant_o  : 0 = ALU granted last, 1 = memory granted last
//   drop_cnt_o    : [7:0] saturating count of accepted writes to ZERO_REG
//                   (present only when REGWB_DROP_CNT_EN is defined)
//
// Optional feature macro: REGWB_DROP_CNT_EN
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 31
) (
    input  logic                clk_i,
    input  logic                reset_i,
    regfile_wb_arbiter_if.slave wb,
    input  logic                clear_i,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   WR_o,
    output logic [DATA_W-1:0]   WD_o,
    output logic                RegWrite_o,
    output logic                last_grant_o
`ifdef REGWB_DROP_CNT_EN
    ,
    output logic [7:0]          drop_cnt_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_busy;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_wr;
    logic [DATA_W-1:0] r_wd;
    logic              r_regwrite;

    logic              w_a_ready;
    logic              w_m_ready;
    logic              w_clr_write;
    logic              w_xfer;
    logic              w_xfer_drop;
    logic [ADDR_W-1:0] w_xfer_addr;
    logic [DATA_W-1:0] w_xfer_data;

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: clear_i only starts a sequence from IDLE; CLEAR leaves
    // after the last register index has been visited
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clear_i) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: grants (clear wins over requesters; contention goes to the
    // source that did not win last) and the clear-write strobe
    always_comb begin
        w_a_ready   = 1'b0;
        w_m_ready   = 1'b0;
        w_clr_write = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_i) begin
                    w_a_ready = 1'b0;
                    w_m_ready = 1'b0;
                end else if (wb.a_valid_i && wb.m_valid_i) begin
                    w_a_ready = r_last_grant;
                    w_m_ready = ~r_last_grant;
                end else begin
                    w_a_ready = wb.a_valid_i;
                    w_m_ready = wb.m_valid_i;
                end
            end
            ST_CLEAR: begin
                w_clr_write = (r_clr_cnt != ZERO_IDX);
            end
            default: begin
                w_a_ready   = 1'b0;
                w_m_ready   = 1'b0;
                w_clr_write = 1'b0;
            end
        endcase
    end

    // Select the granted requester's address and data
    always_comb begin
        if (w_a_ready) begin
            w_xfer_addr = wb.a_addr_i;
            w_xfer_data = wb.a_data_i;
        end else begin
            w_xfer_addr = wb.m_addr_i;
            w_xfer_data = wb.m_data_i;
        end
    end

    assign w_xfer      = w_a_ready | w_m_ready;
    // Writes to the hard-wired zero register complete the handshake but are dropped
    assign w_xfer_drop = w_xfer && (w_xfer_addr == ZERO_IDX);

    assign wb.a_ready_o = w_a_ready;
    assign wb.m_ready_o = w_m_ready;

    // Clear index counter: walks every index while in CLEAR, parked at 0 otherwise
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_clr_cnt <= {ADDR_W{1'b0}};
        end else if (r_state == ST_CLEAR && r_clr_cnt != LAST_IDX) begin
            r_clr_cnt <= r_clr_cnt + ONE_IDX;
        end else begin
            r_clr_cnt <= {ADDR_W{1'b0}};
        end
    end

    // Busy flag tracks the state the FSM is entering
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_CLEAR);
        end
    end

    // Round-robin pointer: remembers the source of the most recent transfer
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_last_grant <= 1'b1;
        end else if (w_a_ready) begin
            r_last_grant <= 1'b0;
        end else if (w_m_ready) begin
            r_last_grant <= 1'b1;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // Register-file write port: clear writes, accepted requests, or idle.
    // WR/WD hold on idle and dropped cycles; only RegWrite falls.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr       <= {ADDR_W{1'b0}};
            r_wd       <= {DATA_W{1'b0}};
            r_regwrite <= 1'b0;
        end else if (w_clr_write) begin
            r_wr       <= r_clr_cnt;
            r_wd       <= {DATA_W{1'b0}};
            r_regwrite <= 1'b1;
        end else if (w_xfer && !w_xfer_drop) begin
            r_wr       <= w_xfer_addr;
            r_wd       <= w_xfer_data;
            r_regwrite <= 1'b1;
        end else begin
            r_wr       <= r_wr;
            r_wd       <= r_wd;
            r_regwrite <= 1'b0;
        end
    end

    assign WR_o         = r_wr;
    assign WD_o         = r_wd;
    assign RegWrite_o   = r_regwrite;
    assign busy_o       = r_busy;
    assign last_grant_o = r_last_grant;

`ifdef REGWB_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of requester writes dropped at the zero register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_drop_cnt <= 8'd0;
        end else if (w_xfer_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Scoreboard bench: the stimulus process issues one directed vector per clock
// and pushes the hand-derived per-cycle expectations (readies, busy,
// last_grant) and the expected register-file writes into queues. The monitor
// samples after each falling edge (and right after an asynchronous reset) and
// pops/compares.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic       ar;
        logic       mr;
        logic       busy;
        logic       lg;
        logic [7:0] dc;
    } cyc_t;

    typedef struct packed {
        logic [4:0]  wr;
        logic [63:0] wd;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        busy;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic        regwrite;
    logic        last_grant;
`ifdef REGWB_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    regfile_wb_arbiter_if #(.DATA_W(64), .ADDR_W(5)) wb_if ();

    regfile_wb_arbiter dut (
        .clk_i        (clk),
        .reset_i      (rst_n),
        .wb           (wb_if.slave),
        .clear_i      (clear),
        .busy_o       (busy),
        .WR_o         (wr),
        .WD_o         (wd),
        .RegWrite_o   (regwrite),
        .last_grant_o (last_grant)
`ifdef REGWB_DROP_CNT_EN
        ,
        .drop_cnt_o   (drop_cnt)
`endif
    );

    cyc_t        cq[$];
    wr_t         wq[$];
    int          checks      = 0;
    int          failures    = 0;
    logic [7:0]  exp_dc      = 8'd0;
    logic        stim_done   = 1'b0;
    logic        final_done  = 1'b0;
    logic [4:0]  hold_wr     = 5'd0;
    logic [63:0] hold_wd     = 64'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- monitor
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        #1;
        if (!rst_n) begin
            chk("rst_regwrite", {63'd0, regwrite}, 64'd0);
            chk("rst_wr", {59'd0, wr}, 64'd0);
            chk("rst_wd", wd, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_last_grant", {63'd0, last_grant}, 64'd1);
`ifdef REGWB_DROP_CNT_EN
            chk("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
`endif
            hold_wr = 5'd0;
            hold_wd = 64'd0;
        end else begin
            if (cq.size() > 0) begin
                cyc_t c;
                c = cq.pop_front();
                chk("a_ready", {63'd0, wb_if.a_ready_o}, {63'd0, c.ar});
                chk("m_ready", {63'd0, wb_if.m_ready_o}, {63'd0, c.mr});
                chk("busy", {63'd0, busy}, {63'd0, c.busy});
                chk("last_grant", {63'd0, last_grant}, {63'd0, c.lg});
`ifdef REGWB_DROP_CNT_EN
                chk("drop_cnt", {56'd0, drop_cnt}, {56'd0, c.dc});
`endif
            end
            if (regwrite === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_wr", {59'd0, wr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_wr", {59'd0, wr}, {59'd0, w.wr});
                    chk("write_wd", wd, w.wd);
                    hold_wr = w.wr;
                    hold_wd = w.wd;
                end
            end else begin
                chk("regwrite_low", {63'd0, regwrite}, 64'd0);
                chk("hold_wr", {59'd0, wr}, {59'd0, hold_wr});
                chk("hold_wd", wd, hold_wd);
            end
            if (stim_done && !final_done) begin
                chk("writes_left", 64'(wq.size()), 64'd0);
                chk("cycles_left", 64'(cq.size()), 64'd0);
                final_done = 1'b1;
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic step(input logic av, input logic [4:0] aad, input logic [63:0] ad,
                        input logic mv, input logic [4:0] mad, input logic [63:0] md,
                        input logic clr, input logic ear, input logic emr,
                        input logic ebusy, input logic elg);
        wb_if.a_valid_i = av;
        wb_if.a_addr_i  = aad;
        wb_if.a_data_i  = ad;
        wb_if.m_valid_i = mv;
        wb_if.m_addr_i  = mad;
        wb_if.m_data_i  = md;
        clear           = clr;
        cq.push_back('{ar: ear, mr: emr, busy: ebusy, lg: elg, dc: exp_dc});
        if (ear && aad != 5'd31) wq.push_back('{wr: aad, wd: ad});
        if (emr && mad != 5'd31) wq.push_back('{wr: mad, wd: md});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic elg);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, elg);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        wq.delete();
        exp_dc = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        clear           = 1'b0;
        wb_if.a_valid_i = 1'b0;
        wb_if.a_addr_i  = 5'd0;
        wb_if.a_data_i  = 64'd0;
        wb_if.m_valid_i = 1'b0;
        wb_if.m_addr_i  = 5'd0;
        wb_if.m_data_i  = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single ALU request, written one cycle later, pointer moves to ALU
        step(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // 2: contention from reset: ALU, MEM, ALU, MEM
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd1, 64'hA1, 1'b1, 5'd2, 64'hB2, 1'b0,
                 (i % 2 == 0), (i % 2 == 1), 1'b0, (i % 2 == 0));
        end
        idle(1'b1);

        // 3: memory write to the zero register: accepted, not written
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        exp_dc = 8'd1;
        idle(1'b1);

        // 4: clear with an ALU request held pending throughout
        step(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (i != 31) wq.push_back('{wr: 5'(i), wd: 64'd0});
        end
        step(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // 5: clear re-requested at index 10 is ignored
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, (i == 10), 1'b0, 1'b0, 1'b1, 1'b0);
            if (i != 31) wq.push_back('{wr: 5'(i), wd: 64'd0});
        end
        idle(1'b0);
        idle(1'b0);

        // 6: asynchronous reset in the middle of a clear at index 15
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            wq.push_back('{wr: 5'(i), wd: 64'd0});
        end
        cq.push_back('{ar: 1'b0, mr: 1'b0, busy: 1'b1, lg: 1'b0, dc: exp_dc});
        do_reset();
        for (int i = 0; i < 34; i++) begin
            idle(1'b1);
        end

        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port controller for the 32 x 64 register file.
- Shares the single write port (WR/WD/RegWrite) between two write-back requesters: ALU (port a) and memory/load (port m).
- Uses valid/ready handshakes and round-robin arbitration.
- Contains a clear sequencer that zeroes every writable register on command, one register per cycle.
- Sits between the execute/memory write-back stages and the register file write inputs.

Parameters:
DATA_W, 64, write data width
ADDR_W, 5, register select width
NUM_REGS, 32, number of register slots
ZERO_REG, 31, hard-wired zero register index; writes to it are dropped

Ports:
clk_i  input  1  clock, all state on rising edge
reset_i  input  1  asynchronous, active-low reset
a_valid_i  input  1  ALU write request valid
a_ready_o  output  1  ALU request accepted this cycle
a_addr_i  input  ADDR_W  ALU destination register
a_data_i  input  DATA_W  ALU write data
m_valid_i  input  1  memory write request valid
m_ready_o  output  1  memory request accepted this cycle
m_addr_i  input  ADDR_W  memory destination register
m_data_i  input  DATA_W  memory write data
clear_i  input  1  pulse: start clear sequence
busy_o  output  1  clear sequence in progress
WR_o  output  ADDR_W  register file write select (registered)
WD_o  output  DATA_W  register file write data (registered)
RegWrite_o  output  1  register file write enable (registered)
last_grant_o  output  1  0 = ALU granted last, 1 = memory granted last

Behaviour:
- Reset (reset_i low, asynchronous):
  - RegWrite_o=0, WR_o=0, WD_o=0, busy_o=0, last_grant_o=1 (ALU wins first contention).
  - FSM goes to IDLE; clear counter=0.
  - Reset mid-clear aborts the sequence with no further writes.
- Handshake:
  - A transfer occurs in a cycle where valid && ready.
  - ready is combinational from the valids, FSM state and last_grant_o.
  - ready is never asserted without the matching valid.
  - A requester holds addr/data stable while valid && !ready.
- Arbitration, IDLE state only:
  - One valid only: that requester is granted.
  - Both valid: grant ALU if last_grant_o=1, else memory.
  - last_grant_o updates to the granted source on every transfer.
  - At most one ready per cycle.
- Write output, latency 1 cycle:
  - The cycle after a transfer: WR_o=addr, WD_o=data, RegWrite_o=1.
  - Exception: addr==ZERO_REG still completes the handshake (ready=1), but RegWrite_o=0 next cycle and WR_o/WD_o hold their previous values.
  - Cycles with no transfer: RegWrite_o=0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_i=1. Clear takes priority: in that cycle a_ready_o=m_ready_o=0.
  - In CLEAR: busy_o=1 and both readies=0.
  - Each cycle in CLEAR, emit on the next cycle WR_o=counter, WD_o=0, RegWrite_o=1, and increment counter. Counter value ZERO_REG is skipped: no write, counter advances.
  - After the write of index NUM_REGS-1 (or ZERO_REG if that is last), return to IDLE and reset counter to 0.
  - With defaults: 31 writes (0..30), 32 cycles in CLEAR. busy_o falls in the cycle the FSM re-enters IDLE.
  - clear_i asserted during CLEAR is ignored (no restart).
- busy_o is registered from FSM state.
- last_grant_o is unchanged by a clear.

Optional Feature:
REGWB_DROP_CNT_EN
- Defined: adds output drop_cnt_o [7:0], reset 0, incremented on each accepted requester transfer to ZERO_REG. It saturates at 255 and is not affected by clear_i.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset low then high; a_valid_i=1, a_addr_i=5, a_data_i=64'hDEAD -> a_ready_o=1 that cycle; next cycle RegWrite_o=1, WR_o=5, WD_o=64'hDEAD, last_grant_o=0.
2. Both valid for 4 cycles (a_addr=1, m_addr=2) after reset -> grant order ALU, MEM, ALU, MEM; WR_o sequence 1,2,1,2 each one cycle later; never both readies high.
3. m_valid_i=1, m_addr_i=31, data=64'h1 -> m_ready_o=1; next cycle RegWrite_o=0. With REGWB_DROP_CNT_EN, drop_cnt_o=1.
4. clear_i pulse with a_valid_i held high -> busy_o=1 for 32 cycles, a_ready_o=0 throughout; RegWrite_o=1 with WD_o=0, WR_o=0..30 on consecutive cycles, no WR_o=31. ALU request accepted in the first IDLE cycle after.
5. clear_i asserted again at clear index 10 -> ignored; sequence completes at index 30 with no restart.
6. reset_i dropped at clear index 15 -> RegWrite_o=0 and busy_o=0 immediately (asynchronous); after release FSM is IDLE and no further clear writes occur.
